// File: rtl/rx_fifo_param_pkg.sv
// Shared types for the UART RX FIFO: alarm codes, threshold helper
// and the default 8-bit data / 4-bit error entry layout.
package uart_fifo_pkg;

   typedef enum logic [2:0] {
      ALARM_1_8 = 3'd0,
      ALARM_1_4 = 3'd1,
      ALARM_1_2 = 3'd2,
      ALARM_3_4 = 3'd3,
      ALARM_7_8 = 3'd4
   } alarm_code_e;

   localparam int ENTRY_DATA_W = 8;
   localparam int ENTRY_ERR_W  = 4;

   typedef struct packed {
      logic [ENTRY_ERR_W-1:0]  err;
      logic [ENTRY_DATA_W-1:0] data;
   } entry_t;

   // Unused codes return depth+1, which no fill level can reach.
   function automatic logic [31:0] alarm_threshold(
      input logic [2:0] code,
      input int         depth
   );
      logic [31:0] d;
      d = 32'(depth);
      case (alarm_code_e'(code))
         ALARM_1_8: return d >> 3;
         ALARM_1_4: return d >> 2;
         ALARM_1_2: return d >> 1;
         ALARM_3_4: return (d * 32'd3) >> 2;
         ALARM_7_8: return (d * 32'd7) >> 3;
         default:   return d + 32'd1;
      endcase
   endfunction

endpackage

// File: rtl/rx_fifo_param_if.sv
// RX FIFO bus: write side from the deserialiser, read side and
// status toward the APB register block.
interface rx_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int ERR_W  = 4,
   parameter int DEPTH  = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic              fifo_en;
   logic              clear;
   logic [DATA_W-1:0] wdata;
   logic [ERR_W-1:0]  werr;
   logic              wdata_valid;
   logic [DATA_W-1:0] rdata;
   logic [ERR_W-1:0]  rerr;
   logic              rdata_valid;
   logic              rdata_taken;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LW-1:0]     fill_level;
   logic [2:0]        fifo_level_for_alarm;
   logic              fifo_alarm;
   logic              overrun_err;
   logic              overrun_clr;
   logic              rx_timeout;

   modport slave (
      input  fifo_en, clear, wdata, werr, wdata_valid,
      input  rdata_taken, fifo_level_for_alarm, overrun_clr,
      output rdata, rerr, rdata_valid, fifo_full, fifo_empty,
      output fill_level, fifo_alarm, overrun_err, rx_timeout
   );

   modport master (
      output fifo_en, clear, wdata, werr, wdata_valid,
      output rdata_taken, fifo_level_for_alarm, overrun_clr,
      input  rdata, rerr, rdata_valid, fifo_full, fifo_empty,
      input  fill_level, fifo_alarm, overrun_err, rx_timeout
   );

endinterface

// File: rtl/rx_fifo_param_mem.sv
// Two-port register file: synchronous write, asynchronous read,
// contents deliberately left unreset.
module fifo_mem_2p #(
   parameter int DEPTH = 16,
   parameter int W     = 12
) (
   input  logic                     CLK,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo_param.sv
// Parametrised UART RX FIFO with holding-register mode, fill alarm and
// overrun flag; idle timeout is built only with RX_FIFO_TIMEOUT_EN.
module rx_fifo_param
   import uart_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ERR_W  = 4,
   parameter int DEPTH  = 16
`ifdef RX_FIFO_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 32
`endif
) (
   input logic       CLK,
   input logic       RSTn,
   rx_fifo_param_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + ERR_W;

   typedef struct packed {
      logic [ERR_W-1:0]  err;
      logic [DATA_W-1:0] data;
   } fifo_entry_t;

   logic [AW:0]  rp, wp, count, cap;
   logic         fifo_en_q, flush, pop, push, we;
   logic         ovr_q, alarm_q, alarm_hit;
   logic [31:0]  thr;
   fifo_entry_t  wentry, rentry;

   assign cap   = bus.fifo_en ? (AW+1)'(DEPTH) : (AW+1)'(1);
   assign flush = bus.clear | (bus.fifo_en ^ fifo_en_q);
   assign pop   = bus.rdata_taken & (count != '0);
   assign push  = bus.wdata_valid & ((count < cap) | pop);
   assign we    = push & ~flush;

   assign wentry = '{err: bus.werr, data: bus.wdata};

   fifo_mem_2p #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_mem (
      .CLK   (CLK),
      .we    (we),
      .waddr (wp[AW-1:0]),
      .wdata (wentry),
      .raddr (rp[AW-1:0]),
      .rdata (rentry)
   );

   // Pointers only move in FIFO mode; mode 0 lives in entry 0.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rp        <= '0;
         wp        <= '0;
         count     <= '0;
         fifo_en_q <= 1'b1;
      end else begin
         fifo_en_q <= bus.fifo_en;
         if (flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
         end else begin
            if (bus.fifo_en && push) wp <= wp + 1'b1;
            if (bus.fifo_en && pop)  rp <= rp + 1'b1;
            unique case (1'b1)
               push & ~pop: count <= count + 1'b1;
               pop & ~push: count <= count - 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      thr       = alarm_threshold(bus.fifo_level_for_alarm, DEPTH);
      alarm_hit = 1'b0;
      if (bus.fifo_en) alarm_hit = 32'(count) >= thr;
      else             alarm_hit = (count == cap);
   end

   // Overrun set beats any clear in the same cycle.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         ovr_q   <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         alarm_q <= alarm_hit;
         if (bus.wdata_valid & ~push & ~flush)
            ovr_q <= 1'b1;
         else if (bus.overrun_clr | bus.clear)
            ovr_q <= 1'b0;
      end
   end

`ifdef RX_FIFO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] idle_cnt;
   logic          rx_to_q;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         idle_cnt <= '0;
         rx_to_q  <= 1'b0;
      end else if (flush | push | pop | (count == '0)) begin
         idle_cnt <= '0;
         rx_to_q  <= 1'b0;
      end else if (idle_cnt != T_MAX) begin
         idle_cnt <= idle_cnt + 1'b1;
         if (idle_cnt == T_MAX - 1'b1) rx_to_q <= 1'b1;
      end
   end

   assign bus.rx_timeout = rx_to_q;
`else
   assign bus.rx_timeout = 1'b0;
`endif

   assign bus.rdata       = rentry.data;
   assign bus.rerr        = rentry.err;
   assign bus.fill_level  = count;
   assign bus.fifo_empty  = (count == '0);
   assign bus.rdata_valid = (count != '0);
   assign bus.fifo_full   = (count == cap);
   assign bus.fifo_alarm  = alarm_q;
   assign bus.overrun_err = ovr_q;

endmodule

// File: tb/tb_rx_fifo_param.sv
// Scoreboard bench for rx_fifo_param (DEPTH=16, 8-bit data, 4-bit err);
// covers the timeout path only when RX_FIFO_TIMEOUT_EN is defined.
module tb_rx_fifo_param;
   import uart_fifo_pkg::*;

   localparam int DEPTH = 16;

   logic   CLK  = 1'b0;
   logic   RSTn = 1'b0;
   int     n_tests = 0;
   int     n_fail  = 0;
   int     cap     = DEPTH;
   entry_t q[$];

   rx_fifo_param_if #(.DATA_W(8), .ERR_W(4), .DEPTH(DEPTH)) bus();

   rx_fifo_param #(
      .DATA_W (8),
      .ERR_W  (4),
      .DEPTH  (DEPTH)
   ) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   // One clock of stimulus; model decides acceptance, head checked on pop.
   task automatic drive(input logic wv, input logic [7:0] wd,
                        input logic [3:0] we_, input logic rt);
      logic pop_m, acc;
      bus.wdata_valid = wv;
      bus.wdata       = wd;
      bus.werr        = we_;
      bus.rdata_taken = rt;
      pop_m = rt && (q.size() > 0);
      if (pop_m) begin
         n_tests++;
         if (bus.rdata !== q[0].data || bus.rerr !== q[0].err) begin
            n_fail++;
            $display("FAIL pop_head got %h/%h exp %h/%h",
                     bus.rdata, bus.rerr, q[0].data, q[0].err);
         end
      end
      acc = wv && ((q.size() < cap) || pop_m);
      @(posedge CLK);
      #1;
      if (pop_m) void'(q.pop_front());
      if (acc) q.push_back('{err: we_, data: wd});
      bus.wdata_valid = 1'b0;
      bus.rdata_taken = 1'b0;
      n_tests++;
      if (bus.fill_level !== 5'(q.size())) begin
         n_fail++;
         $display("FAIL fill_level got %0d exp %0d",
                  bus.fill_level, q.size());
      end
   endtask

   task automatic test_reset();
      bus.fifo_en = 1'b1;
      bus.clear = 1'b0;
      bus.wdata = '0;
      bus.werr = '0;
      bus.wdata_valid = 1'b0;
      bus.rdata_taken = 1'b0;
      bus.fifo_level_for_alarm = 3'd2;
      bus.overrun_clr = 1'b0;
      RSTn = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_tests++;
      if ({bus.fifo_empty, bus.rdata_valid, bus.fifo_full} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_flags got %b exp 100",
                  {bus.fifo_empty, bus.rdata_valid, bus.fifo_full});
      end
      n_tests++;
      if (bus.fill_level !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_fill got %0d exp 0", bus.fill_level);
      end
      n_tests++;
      if ({bus.fifo_alarm, bus.overrun_err, bus.rx_timeout} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_status got %b exp 000",
                  {bus.fifo_alarm, bus.overrun_err, bus.rx_timeout});
      end
      RSTn = 1'b1;
      repeat (2) drive(1'b0, 8'h00, 4'h0, 1'b0);
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++)
         drive(1'b1, 8'(i), 4'($urandom), 1'b0);
      n_tests++;
      if (bus.fifo_full !== 1'b1) begin
         n_fail++;
         $display("FAIL fd_full got %b exp 1", bus.fifo_full);
      end
      drive(1'b1, 8'hFF, 4'hF, 1'b0);
      n_tests++;
      if (bus.overrun_err !== 1'b1) begin
         n_fail++;
         $display("FAIL fd_overrun got %b exp 1", bus.overrun_err);
      end
      bus.overrun_clr = 1'b1;
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      bus.overrun_clr = 1'b0;
      n_tests++;
      if (bus.overrun_err !== 1'b0) begin
         n_fail++;
         $display("FAIL fd_ovr_clr got %b exp 0", bus.overrun_err);
      end
      for (int i = 0; i < 16; i++)
         drive(1'b0, 8'h00, 4'h0, 1'b1);
      n_tests++;
      if (bus.fifo_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL fd_empty got %b exp 1", bus.fifo_empty);
      end
   endtask

   task automatic test_alarm();
      bus.fifo_level_for_alarm = 3'b010;
      for (int i = 0; i < 7; i++)
         drive(1'b1, 8'(8'h40 + i), 4'($urandom), 1'b0);
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.fifo_alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_7 got %b exp 0", bus.fifo_alarm);
      end
      drive(1'b1, 8'h47, 4'h1, 1'b0);
      n_tests++;
      if (bus.fifo_alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_lat got %b exp 0", bus.fifo_alarm);
      end
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.fifo_alarm !== 1'b1) begin
         n_fail++;
         $display("FAIL alarm_8 got %b exp 1", bus.fifo_alarm);
      end
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.fifo_alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_pop got %b exp 0", bus.fifo_alarm);
      end
      bus.fifo_level_for_alarm = 3'b101;
      for (int i = 0; i < 9; i++)
         drive(1'b1, 8'(8'h50 + i), 4'($urandom), 1'b0);
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.fifo_alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_101 got %b exp 0", bus.fifo_alarm);
      end
      bus.fifo_level_for_alarm = 3'b100;
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.fifo_alarm !== 1'b1) begin
         n_fail++;
         $display("FAIL alarm_7_8 got %b exp 1", bus.fifo_alarm);
      end
      for (int i = 0; i < 16; i++)
         drive(1'b0, 8'h00, 4'h0, 1'b1);
      bus.fifo_level_for_alarm = 3'b010;
   endtask

   task automatic test_hold_mode();
      bus.fifo_en = 1'b0;
      cap = 1;
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      drive(1'b1, 8'hA5, 4'b0010, 1'b0);
      n_tests++;
      if ({bus.fifo_full, bus.rdata, bus.rerr} !== {1'b1, 8'hA5, 4'b0010}) begin
         n_fail++;
         $display("FAIL hold_word got %b/%h/%b exp 1/a5/0010",
                  bus.fifo_full, bus.rdata, bus.rerr);
      end
      drive(1'b1, 8'h5A, 4'b0000, 1'b0);
      n_tests++;
      if ({bus.overrun_err, bus.fifo_alarm, bus.rdata} !== {2'b11, 8'hA5}) begin
         n_fail++;
         $display("FAIL hold_ovr got %b/%b/%h exp 1/1/a5",
                  bus.overrun_err, bus.fifo_alarm, bus.rdata);
      end
      bus.overrun_clr = 1'b1;
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      bus.overrun_clr = 1'b0;
      n_tests++;
      if (bus.overrun_err !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_clr got %b exp 0", bus.overrun_err);
      end
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      n_tests++;
      if (bus.fifo_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_empty got %b exp 1", bus.fifo_empty);
      end
      bus.fifo_en = 1'b1;
      cap = DEPTH;
      repeat (2) drive(1'b0, 8'h00, 4'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++)
         drive(1'b1, 8'(8'h20 + i), 4'($urandom), 1'b0);
      for (int k = 0; k < 4; k++)
         drive(1'b1, 8'(8'h80 + k), 4'($urandom), 1'b1);
      n_tests++;
      if ({bus.fifo_full, bus.overrun_err} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_full got %b/%b exp 1/0",
                  bus.fifo_full, bus.overrun_err);
      end
      for (int i = 0; i < 16; i++)
         drive(1'b0, 8'h00, 4'h0, 1'b1);
      drive(1'b1, 8'h99, 4'h3, 1'b1);
      drive(1'b0, 8'h00, 4'h0, 1'b1);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++)
         drive(1'b1, 8'(8'h60 + i), 4'($urandom), 1'b0);
      bus.fifo_en = 1'b0;
      cap = 1;
      q.delete();
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.rdata_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL toggle_valid got %b exp 0", bus.rdata_valid);
      end
      bus.fifo_en = 1'b1;
      cap = DEPTH;
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      for (int i = 0; i < 16; i++)
         drive(1'b1, 8'(8'h70 + i), 4'($urandom), 1'b0);
      bus.clear = 1'b1;
      bus.wdata_valid = 1'b1;
      bus.wdata = 8'hEE;
      @(posedge CLK);
      #1;
      bus.clear = 1'b0;
      bus.wdata_valid = 1'b0;
      q.delete();
      n_tests++;
      if ({bus.fill_level, bus.rdata_valid, bus.overrun_err} !== 7'd0) begin
         n_fail++;
         $display("FAIL clear got %0d/%b/%b exp 0/0/0",
                  bus.fill_level, bus.rdata_valid, bus.overrun_err);
      end
      bus.fifo_level_for_alarm = 3'b000;
      for (int i = 0; i < 3; i++)
         drive(1'b1, 8'(8'h30 + i), 4'($urandom), 1'b0);
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.fifo_alarm !== 1'b1) begin
         n_fail++;
         $display("FAIL alarm_1_8 got %b exp 1", bus.fifo_alarm);
      end
      bus.wdata_valid = 1'b1;
      RSTn = 1'b0;
      #2;
      n_tests++;
      if ({bus.fill_level, bus.fifo_empty, bus.rdata_valid, bus.fifo_alarm}
          !== {5'd0, 3'b100}) begin
         n_fail++;
         $display("FAIL async_rst got %0d/%b/%b/%b exp 0/1/0/0",
                  bus.fill_level, bus.fifo_empty, bus.rdata_valid,
                  bus.fifo_alarm);
      end
      q.delete();
      bus.wdata_valid = 1'b0;
      @(posedge CLK);
      #1;
      RSTn = 1'b1;
      bus.fifo_level_for_alarm = 3'b010;
      repeat (2) drive(1'b0, 8'h00, 4'h0, 1'b0);
   endtask

   task automatic test_timeout();
      drive(1'b1, 8'hC3, 4'h8, 1'b0);
`ifdef RX_FIFO_TIMEOUT_EN
      repeat (31) drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.rx_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_early got %b exp 0", bus.rx_timeout);
      end
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.rx_timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL to_set got %b exp 1", bus.rx_timeout);
      end
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      n_tests++;
      if (bus.rx_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_pop got %b exp 0", bus.rx_timeout);
      end
`else
      repeat (40) drive(1'b0, 8'h00, 4'h0, 1'b0);
      n_tests++;
      if (bus.rx_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_off got %b exp 0", bus.rx_timeout);
      end
      drive(1'b0, 8'h00, 4'h0, 1'b1);
`endif
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_alarm();
      test_hold_mode();
      test_back_to_back();
      test_flush();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_fifo_param.md
Name: rx_fifo_param

Overview:
Parametrised single-clock receive FIFO for the UART datapath, sitting between the RX deserialiser and the APB register interface.
- Generalises the 16x8 RX FIFO to configurable data width, depth and per-entry error-flag width.
- Uses every entry: DEPTH words, not DEPTH-1.
- Adds fill-level output, eighths-based alarm thresholds scaled to DEPTH, a defined flush/clear, and a proper 1-word holding-register mode.

Parameters:
DATA_W, 8, data bits per entry
ERR_W, 4, error-flag bits stored alongside each entry (framing/parity/break/spare)
DEPTH, 16, entries; power of two, >= 8
TIMEOUT_CYCLES, 32, idle cycles before rx_timeout; used only with RX_FIFO_TIMEOUT_EN

Ports:
CLK  in  1  clock
RSTn  in  1  reset, active-low, asynchronous assert
fifo_en  in  1  1 = DEPTH-entry FIFO, 0 = 1-entry holding register
clear  in  1  synchronous flush pulse
wdata  in  DATA_W  write data
werr  in  ERR_W  error flags for wdata
wdata_valid  in  1  single-cycle write strobe, one per word
rdata  out  DATA_W  head-of-FIFO data (first-word fall-through)
rerr  out  ERR_W  head-of-FIFO error flags
rdata_valid  out  1  FIFO non-empty
rdata_taken  in  1  pop head this cycle
fifo_full  out  1  count == capacity
fifo_empty  out  1  count == 0
fill_level  out  $clog2(DEPTH)+1  current count
fifo_level_for_alarm  in  3  threshold code
fifo_alarm  out  1  fill at/above threshold
overrun_err  out  1  sticky dropped-write flag
overrun_clr  in  1  clears overrun_err
rx_timeout  out  1  non-empty FIFO idle too long

Behaviour:
- Reset (async, RSTn=0):
  - Pointers and count are 0. fifo_empty=1, rdata_valid=0, fifo_full=0, fill_level=0.
  - fifo_alarm=0, overrun_err=0, rx_timeout=0.
  - Storage array is not reset.
- Pointers and capacity:
  - rp and wp are log2(DEPTH)+1 bits; the MSB is the wrap bit, so wrap-around of index bits is natural.
  - Registered count register. capacity = fifo_en ? DEPTH : 1. In mode 0 only entry 0 is used and both pointers are held at 0.
- Write and read acceptance:
  - Write accepted when wdata_valid && (count < capacity || pop this cycle).
  - Pop when rdata_taken && count > 0. rdata_taken while empty is ignored.
  - Simultaneous accepted write and pop: count unchanged, order preserved, including when full.
- Latency:
  - A word written at edge N appears on rdata/rdata_valid and fill_level after edge N.
  - fifo_full, fifo_empty and rdata_valid decode the registered count combinationally.
  - rdata/rerr are combinational from mem[rp] and are don't-care while rdata_valid=0.
- Overrun:
  - A write that is not accepted is dropped, stored contents are untouched, and overrun_err is set next cycle.
  - Cleared by overrun_clr or clear. If a set and a clear coincide, set wins.
- Flush:
  - clear, or any change of fifo_en (edge detected on a registered copy), zeroes pointers and count on the next edge.
  - A write in the same cycle as a flush is discarded. The flush itself does not set overrun.
- Alarm (registered, updates the cycle after fill_level changes):
  - Codes 000/001/010/011/100 give thresholds DEPTH/8, DEPTH/4, DEPTH/2, 3*DEPTH/4, 7*DEPTH/8.
  - fifo_alarm = count >= threshold. Codes 101-111 force 0.
  - In mode 0, fifo_alarm = fifo_full.

Optional Feature:
RX_FIFO_TIMEOUT_EN
- Defined:
  - An idle counter increments each cycle while count > 0 and there is no accepted write or pop. It resets on accept, pop, flush or empty.
  - rx_timeout is registered and asserts when the counter reaches TIMEOUT_CYCLES, then holds until pop, accepted write, flush or reset.
  - Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates.
- Undefined: rx_timeout tied 0 and no counter logic is generated.

Decomposition:
- Package uart_fifo_pkg holds:
  - alarm-code enum (ALARM_1_8 .. ALARM_7_8);
  - function alarm_threshold(code, depth);
  - entry struct {err, data}.
- One sub-module, fifo_mem_2p: DEPTH x (DATA_W+ERR_W) register file with synchronous write and asynchronous read, no reset.

Test Plan:
1. Defaults, fifo_en=1: write 0x00..0x0F -> after 16th write fifo_full=1, fill_level=16. A 17th write 0xFF -> overrun_err=1 next cycle. Pops return 0x00..0x0F in order, then fifo_empty=1.
2. Code 010, DEPTH=16: 7 writes -> fifo_alarm=0. 8th write -> fifo_alarm=1 one cycle after fill_level=8. One pop -> fifo_alarm=0 next cycle. Code 101 with 16 words -> fifo_alarm stays 0.
3. fifo_en=0: write 0xA5 with werr=4'b0010 -> full=1, alarm=1, rdata=0xA5, rerr=0010. Write 0x5A -> overrun_err=1, rdata still 0xA5. overrun_clr -> overrun_err=0. Pop -> empty=1.
4. Full (16 words) with wdata_valid and rdata_taken together -> fill_level stays 16, no overrun, sequence intact. Empty with both -> pop ignored, fill_level=1.
5. Five words queued, then toggle fifo_en -> next cycle fill_level=0, rdata_valid=0. Pulse RSTn low mid-burst -> outputs at reset values immediately, without waiting for a clock edge.
6. With RX_FIFO_TIMEOUT_EN and TIMEOUT_CYCLES=32: one write, then idle -> rx_timeout=1 after the 32nd idle cycle. Pop -> rx_timeout=0 next cycle. Without the macro -> rx_timeout stays 0.
